// File: rtl/jlsemi_util_clksel_pkg.sv
// Shared types and elaboration helpers for the clock-select sequencer.
package jlsemi_util_clksel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OFF = 2'd1,
        ST_WAIT_SW  = 2'd2,
        ST_WAIT_ON  = 2'd3
    } clksel_state_e;

    // Counter width wide enough for the longest of the three waits.
    function automatic int cnt_width(input int off_cyc, input int sw_cyc, input int on_cyc);
        int mx;
        mx = off_cyc;
        if (sw_cyc > mx) mx = sw_cyc;
        if (on_cyc > mx) mx = on_cyc;
        return $clog2(mx) + 1;
    endfunction

    // A zero-cycle wait would make a phase vanish and defeat the gating order.
    function automatic bit wait_cyc_legal(input int off_cyc, input int sw_cyc, input int on_cyc);
        return (off_cyc >= 1) && (sw_cyc >= 1) && (on_cyc >= 1);
    endfunction

endpackage

// File: rtl/jlsemi_util_wait_cnt.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module jlsemi_util_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/jlsemi_util_clksel_ctrl.sv
// Clock-mux select sequencer: gate off, switch select, gate on, report done.
//
// state       | meaning
// ST_IDLE     | waiting for a request, gate enabled
// ST_WAIT_OFF | gate dropped, letting the consumer settle before the switch
// ST_WAIT_SW  | select changed, letting the mux settle before re-enabling
// ST_WAIT_ON  | gate re-enabled, waiting before reporting completion
module jlsemi_util_clksel_ctrl
    import jlsemi_util_clksel_pkg::*;
#(
    parameter logic RST_SEL      = 1'b0,
    parameter int   OFF_WAIT_CYC = 8,
    parameter int   SW_WAIT_CYC  = 16,
    parameter int   ON_WAIT_CYC  = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_vld_i,
    input  logic req_sel_i,
    output logic req_rdy_o,
    input  logic dft_test_clk_en_i,
    output logic clk_sel_o,
    output logic clk_gate_en_o,
    output logic busy_o,
    output logic done_o,
    output logic abort_o
);

    localparam int CW = cnt_width(OFF_WAIT_CYC, SW_WAIT_CYC, ON_WAIT_CYC);
    localparam logic [CW-1:0] OFF_LD = CW'(OFF_WAIT_CYC - 1);
    localparam logic [CW-1:0] SW_LD  = CW'(SW_WAIT_CYC - 1);
    localparam logic [CW-1:0] ON_LD  = CW'(ON_WAIT_CYC - 1);

    if (!wait_cyc_legal(OFF_WAIT_CYC, SW_WAIT_CYC, ON_WAIT_CYC)) begin : g_bad_wait
        $error("jlsemi_util_clksel_ctrl: every *_WAIT_CYC must be at least 1");
    end

    clksel_state_e  state_q, state_d;
    logic           sel_q, sel_d;
    logic           tgt_q, tgt_d;
    logic           gate_q, gate_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;
    logic           cnt_load;
    logic [CW-1:0]  cnt_load_val;
    logic           cnt_expired;

    jlsemi_util_wait_cnt #(.W(CW)) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .expired_o  (cnt_expired)
    );

    assign req_rdy_o = (state_q == ST_IDLE) & ~dft_test_clk_en_i;

    // Next-state and next-output decode; DFT override beats any phase expiry.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tgt_d        = tgt_q;
        gate_d       = gate_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        if ((state_q != ST_IDLE) && dft_test_clk_en_i) begin
            state_d = ST_IDLE;
            gate_d  = 1'b1;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_vld_i && req_rdy_o) begin
                        if (req_sel_i == sel_q) begin
                            done_d = 1'b1;
                        end else begin
                            tgt_d        = req_sel_i;
                            gate_d       = 1'b0;
                            cnt_load     = 1'b1;
                            cnt_load_val = OFF_LD;
                            state_d      = ST_WAIT_OFF;
                        end
                    end
                end
                ST_WAIT_OFF: begin
                    if (cnt_expired) begin
                        sel_d        = tgt_q;
                        cnt_load     = 1'b1;
                        cnt_load_val = SW_LD;
                        state_d      = ST_WAIT_SW;
                    end
                end
                ST_WAIT_SW: begin
                    if (cnt_expired) begin
                        gate_d       = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = ON_LD;
                        state_d      = ST_WAIT_ON;
                    end
                end
                ST_WAIT_ON: begin
                    if (cnt_expired) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and flopped outputs with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            sel_q   <= RST_SEL;
            tgt_q   <= RST_SEL;
            gate_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign clk_sel_o     = sel_q;
    assign clk_gate_en_o = gate_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign abort_o       = abort_q;

endmodule

// File: tb/tb_jlsemi_util_clksel_ctrl.sv
// Directed bench for the clock-select sequencer: a default-parameter instance
// plus a minimum-wait instance with RST_SEL=1.
module tb_jlsemi_util_clksel_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dft = 1'b0;
    logic vld0 = 1'b0, sel0 = 1'b0;
    logic vld1 = 1'b0, sel1 = 1'b0;
    logic rdy0, sel_o0, gate0, busy0, done0, abort0;
    logic rdy1, sel_o1, gate1, busy1, done1, abort1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jlsemi_util_clksel_ctrl #(
        .RST_SEL(1'b0), .OFF_WAIT_CYC(8), .SW_WAIT_CYC(16), .ON_WAIT_CYC(8)
    ) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_vld_i(vld0), .req_sel_i(sel0),
        .req_rdy_o(rdy0), .dft_test_clk_en_i(dft), .clk_sel_o(sel_o0),
        .clk_gate_en_o(gate0), .busy_o(busy0), .done_o(done0), .abort_o(abort0)
    );

    jlsemi_util_clksel_ctrl #(
        .RST_SEL(1'b1), .OFF_WAIT_CYC(1), .SW_WAIT_CYC(1), .ON_WAIT_CYC(1)
    ) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_vld_i(vld1), .req_sel_i(sel1),
        .req_rdy_o(rdy1), .dft_test_clk_en_i(dft), .clk_sel_o(sel_o1),
        .clk_gate_en_o(gate1), .busy_o(busy1), .done_o(done1), .abort_o(abort1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dft = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
        repeat (3) tick();
        checks++; if (sel_o0 !== 1'b0) begin errors++; $display("FAIL reset_sel0 got=%b exp=0", sel_o0); end
        checks++; if (gate0 !== 1'b1) begin errors++; $display("FAIL reset_gate0 got=%b exp=1", gate0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0); end
        checks++; if ({done0, abort0} !== 2'b00) begin errors++; $display("FAIL reset_pulses0 got=%b exp=00", {done0, abort0}); end
        checks++; if (sel_o1 !== 1'b1) begin errors++; $display("FAIL reset_sel1 got=%b exp=1", sel_o1); end
        checks++; if ({gate1, busy1, rdy1} !== 3'b101) begin errors++; $display("FAIL reset_dut1 gate/busy/rdy got=%b exp=101", {gate1, busy1, rdy1}); end
        rst_n = 1'b1;
        tick();
    endtask

    // Minimum 1/1/1 waits on u_dut1: select 1 -> 0, done after E+3.
    task automatic test_min_params();
        logic [3:0] exp_tbl [0:4];
        exp_tbl[0] = 4'b1010; // {sel,gate,busy,done} after E
        exp_tbl[1] = 4'b0010;
        exp_tbl[2] = 4'b0110;
        exp_tbl[3] = 4'b0101;
        exp_tbl[4] = 4'b0100;
        sel1 = 1'b0; vld1 = 1'b1;
        tick();
        vld1 = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            checks++;
            if ({sel_o1, gate1, busy1, done1} !== exp_tbl[k])
                begin errors++; $display("FAIL min_params E+%0d sel/gate/busy/done got=%b exp=%b", k, {sel_o1, gate1, busy1, done1}, exp_tbl[k]); end
        end
    endtask

    task automatic test_same_sel();
        sel0 = 1'b0; vld0 = 1'b1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL same_sel_rdy got=%b exp=1", rdy0); end
        tick();
        vld0 = 1'b0;
        checks++; if ({done0, gate0, busy0, sel_o0} !== 4'b1100) begin errors++; $display("FAIL same_sel_E0 done/gate/busy/sel got=%b exp=1100", {done0, gate0, busy0, sel_o0}); end
        tick();
        checks++; if ({done0, gate0, busy0} !== 3'b010) begin errors++; $display("FAIL same_sel_E1 done/gate/busy got=%b exp=010", {done0, gate0, busy0}); end
    endtask

    // Full default sequence on u_dut0 from from_sel to ~from_sel.
    task automatic test_switch(input logic from_sel);
        logic es, eg, ed, eb;
        sel0 = ~from_sel; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        checks++; if ({gate0, busy0, sel_o0, rdy0, done0} !== {2'b01, from_sel, 2'b00})
            begin errors++; $display("FAIL switch_E0 gate/busy/sel/rdy/done got=%b exp=%b", {gate0, busy0, sel_o0, rdy0, done0}, {2'b01, from_sel, 2'b00}); end
        for (int k = 1; k <= 33; k++) begin
            tick();
            es = (k >= 8) ? ~from_sel : from_sel;
            eg = (k >= 24);
            ed = (k == 32);
            eb = (k < 32);
            checks++;
            if ({sel_o0, gate0, done0, busy0, abort0} !== {es, eg, ed, eb, 1'b0})
                begin errors++; $display("FAIL switch E+%0d sel/gate/done/busy/abort got=%b exp=%b", k, {sel_o0, gate0, done0, busy0, abort0}, {es, eg, ed, eb, 1'b0}); end
        end
    endtask

    // Second request held while busy; accepted on the edge closing the done cycle (E+33).
    task automatic test_back_to_back();
        logic es, eg, ed, eb;
        sel0 = 1'b0; vld0 = 1'b1;
        tick();
        sel0 = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            tick();
            es = (k >= 8 && k < 41) ? 1'b0 : 1'b1;
            eg = (k >= 24 && k < 33) || (k >= 57);
            ed = (k == 32) || (k == 65);
            eb = (k < 32) || (k >= 33 && k < 65);
            checks++;
            if ({sel_o0, gate0, done0, busy0, rdy0} !== {es, eg, ed, eb, ~eb})
                begin errors++; $display("FAIL b2b E+%0d sel/gate/done/busy/rdy got=%b exp=%b", k, {sel_o0, gate0, done0, busy0, rdy0}, {es, eg, ed, eb, ~eb}); end
            if (k == 33) vld0 = 1'b0;
        end
    endtask

    // Reset asserted at E+20 of a 1 -> 0 switch.
    task automatic test_reset_mid();
        sel0 = 1'b0; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        repeat (19) tick();
        checks++; if ({sel_o0, gate0, busy0} !== 3'b001) begin errors++; $display("FAIL rstmid_pre sel/gate/busy got=%b exp=001", {sel_o0, gate0, busy0}); end
        rst_n = 1'b0;
        tick();
        checks++; if ({sel_o0, gate0, busy0, done0, abort0} !== 5'b01000)
            begin errors++; $display("FAIL rstmid sel/gate/busy/done/abort got=%b exp=01000", {sel_o0, gate0, busy0, done0, abort0}); end
        checks++; if (sel_o1 !== 1'b1) begin errors++; $display("FAIL rstmid_dut1_sel got=%b exp=1", sel_o1); end
        rst_n = 1'b1;
        tick();
        checks++; if ({done0, abort0, rdy0} !== 3'b001) begin errors++; $display("FAIL rstmid_post done/abort/rdy got=%b exp=001", {done0, abort0, rdy0}); end
        test_switch(1'b0);
    endtask

    // DFT raised so it is sampled on edge E+12, mid WAIT_SW of a 1 -> 0 switch.
    task automatic test_dft_abort();
        sel0 = 1'b0; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        repeat (11) tick();
        checks++; if ({busy0, gate0, sel_o0, abort0} !== 4'b1000) begin errors++; $display("FAIL dft_pre busy/gate/sel/abort got=%b exp=1000", {busy0, gate0, sel_o0, abort0}); end
        dft = 1'b1;
        #1;
        checks++; if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL dft_rdy_block got=%b exp=00", {rdy0, rdy1}); end
        tick();
        checks++; if ({abort0, done0, gate0, busy0, sel_o0} !== 5'b10100)
            begin errors++; $display("FAIL dft_abort abort/done/gate/busy/sel got=%b exp=10100", {abort0, done0, gate0, busy0, sel_o0}); end
        checks++; if ({rdy0, abort1, busy1} !== 3'b000) begin errors++; $display("FAIL dft_idle rdy0/abort1/busy1 got=%b exp=000", {rdy0, abort1, busy1}); end
        sel0 = 1'b1; vld0 = 1'b1;
        tick();
        checks++; if ({abort0, done0, busy0, gate0, sel_o0} !== 5'b00010)
            begin errors++; $display("FAIL dft_held abort/done/busy/gate/sel got=%b exp=00010", {abort0, done0, busy0, gate0, sel_o0}); end
        repeat (3) tick();
        checks++; if ({busy0, rdy0, abort0} !== 3'b000) begin errors++; $display("FAIL dft_blocked busy/rdy/abort got=%b exp=000", {busy0, rdy0, abort0}); end
        dft = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL dft_release_rdy got=%b exp=1", rdy0); end
        tick();
        vld0 = 1'b0;
        checks++; if ({busy0, gate0, done0} !== 3'b100) begin errors++; $display("FAIL dft_after_accept busy/gate/done got=%b exp=100", {busy0, gate0, done0}); end
    endtask

    initial begin
        test_reset();
        test_min_params();
        test_same_sel();
        test_switch(1'b0);
        test_back_to_back();
        test_reset_mid();
        test_dft_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
